// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// alu_serial : slice-serial ALU, one WIDTH-bit slice per clock, LS slice first
// Rev 1.0
// ============================================================================
module alu_serial #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   b_inv,
  input  logic                   y,
  input  logic [1:0]             op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   c,
  output logic                   zero,
  output logic                   overflow,
  output logic                   busy
);

  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [N-1:0]      s_q, s_d;
  logic [1:0]        op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              c_q, c_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  a_sl_w, b_sl_w, res_sl_w;
  logic [WIDTH:0]    sum_w;
  logic              cout_w;
  logic [N-1:0]      s_full_w;

  // Current slice datapath; s_full_w is the result word with this slice merged in.
  always_comb begin
    a_sl_w   = a_q[idx_q*WIDTH +: WIDTH];
    b_sl_w   = b_q[idx_q*WIDTH +: WIDTH];
    sum_w    = {1'b0, a_sl_w} + {1'b0, b_sl_w} + {{WIDTH{1'b0}}, carry_q};
    res_sl_w = sum_w[WIDTH-1:0];
    cout_w   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_sl_w = sum_w[WIDTH-1:0];
        cout_w   = sum_w[WIDTH];
      end
      OP_AND:  res_sl_w = a_sl_w & b_sl_w;
      OP_OR:   res_sl_w = a_sl_w | b_sl_w;
      OP_XOR:  res_sl_w = a_sl_w ^ b_sl_w;
      default: res_sl_w = '0;
    endcase
    s_full_w = s_q;
    s_full_w[idx_q*WIDTH +: WIDTH] = res_sl_w;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    op_d    = op_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_d     = c_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {N{b_inv}};
          op_d    = op;
          carry_d = y;
          idx_d   = '0;
          s_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        s_d     = s_full_w;
        carry_d = cout_w;
        if (idx_q == LAST_IDX) begin
          // Flags come from the completed word, so they are taken on the last slice.
          c_d     = cout_w;
          zero_d  = ~|s_full_w;
          ovf_d   = (op_q == OP_ADD) && (a_q[N-1] == b_q[N-1]) && (s_full_w[N-1] != a_q[N-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign s         = s_q;
  assign c         = c_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
// tb_alu_serial : randomized and directed checks of alu_serial against a word-level model
// Rev 1.0
// ============================================================================
module tb_alu_serial;

  localparam int WIDTH = 4;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [N-1:0] a, b;
  logic         b_inv, y;
  logic [1:0]   op;
  logic         out_valid, out_ready;
  logic [N-1:0] s;
  logic         c, zero, overflow, busy;

  int errors = 0;
  int checks = 0;

  alu_serial #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_inv(b_inv), .y(y), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c(c), .zero(zero), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Whole-word reference: N-bit arithmetic, no slicing.
  function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                input logic minv, input logic my, input logic [1:0] mop,
                                output logic [N-1:0] es, output logic ec,
                                output logic ez, output logic ev);
    logic [N-1:0] beff;
    logic [N:0]   full;
    beff = minv ? ~mb : mb;
    ec = 1'b0;
    ev = 1'b0;
    case (mop)
      2'b00: begin
        full = {1'b0, ma} + {1'b0, beff} + (N+1)'(my);
        es   = full[N-1:0];
        ec   = full[N];
        ev   = (ma[N-1] == beff[N-1]) && (es[N-1] != ma[N-1]);
      end
      2'b01:   es = ma & beff;
      2'b10:   es = ma | beff;
      default: es = ma ^ beff;
    endcase
    ez = (es == '0);
  endfunction

  // Drive one request; returns #1 after the accepting edge with inputs scrambled.
  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tinv, input logic ty, input logic [1:0] top);
    a = ta; b = tb; b_inv = tinv; y = ty; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); b_inv = 1'($urandom); y = 1'($urandom); op = 2'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < WORDS + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout out_valid: got %b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tinv,
                       input logic ty, input logic [1:0] top,
                       output logic [N-1:0] rs, output logic rc, output logic rz,
                       output logic rv, output int lat);
    start_op(ta, tb, tinv, ty, top);
    wait_valid(lat);
    rs = s; rc = c; rz = zero; rv = overflow;
    release_result();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy, s, c, zero, overflow} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b busy=%b s=%h c=%b z=%b v=%b, required 1 0 0 0000 0 0 0",
               in_ready, out_valid, busy, s, c, zero, overflow);
    end
  endtask

  // Directed table: a, b, b_inv, y, op, expected s, c, zero, overflow.
  task automatic test_directed();
    logic [N-1:0] ta[9], tb[9], es[9];
    logic [1:0]   top[9];
    logic         tinv[9], ty[9], ec[9], ez[9], ev[9];
    logic [N-1:0] rs;
    logic         rc, rz, rv;
    int           lat;
    ta = '{16'h7FFF, 16'hFFFF, 16'h0FFF, 16'h1234, 16'h8000, 16'hA5A5, 16'hF0F0, 16'h1200, 16'h0001};
    tb = '{16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h0001, 16'hFFFF, 16'hF0F0, 16'h0034, 16'h0001};
    tinv = '{0, 0, 0, 1, 1, 0, 1, 0, 0};
    ty   = '{0, 0, 0, 1, 1, 1, 0, 1, 1};
    top  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    es = '{16'h8000, 16'h0000, 16'h1000, 16'h0000, 16'h7FFF, 16'h5A5A, 16'h0000, 16'h1234, 16'h0003};
    ec = '{0, 1, 0, 1, 1, 0, 0, 0, 0};
    ez = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
    ev = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      do_op(ta[i], tb[i], tinv[i], ty[i], top[i], rs, rc, rz, rv, lat);
      checks++;
      if ({rs, rc, rz, rv} !== {es[i], ec[i], ez[i], ev[i]}) begin
        errors++;
        $display("FAIL directed[%0d]: got s=%h c=%b z=%b v=%b, required s=%h c=%b z=%b v=%b",
                 i, rs, rc, rz, rv, es[i], ec[i], ez[i], ev[i]);
      end
      checks++;
      if (lat != WORDS) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d, required %0d", i, lat, WORDS);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rs;
    logic         rc, rz, rv;
    int           lat;
    start_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 2'b00);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = N'($urandom); b = N'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy, s, c, zero, overflow} !== {1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b busy=%b s=%h c=%b z=%b v=%b, required 1 0 1 1000 0 0 0",
                 i, out_valid, in_ready, busy, s, c, zero, overflow);
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL release: got vld=%b rdy=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
    do_op(16'h4000, 16'h4000, 1'b0, 1'b0, 2'b00, rs, rc, rz, rv, lat);
    checks++;
    if ({rs, rc, rz, rv} !== {16'h8000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL after_hold: got s=%h c=%b z=%b v=%b, required s=8000 c=0 z=0 v=1", rs, rc, rz, rv);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] rs;
    logic         rc, rz, rv;
    int           lat;
    start_op(16'h1111, 16'h1111, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_valid[%0d]: got %b, required 0", i, out_valid);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, s, c, zero, overflow} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b s=%h c=%b z=%b v=%b, required 1 0 0 0000 0 0 0",
               in_ready, out_valid, busy, s, c, zero, overflow);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (WORDS + 2) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL aborted_valid: got %b, required 0", out_valid);
      end
    end
    do_op(16'h1234, 16'h4321, 1'b0, 1'b1, 2'b00, rs, rc, rz, rv, lat);
    checks++;
    if ({rs, rc, rz, rv} !== {16'h5556, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_add: got s=%h c=%b z=%b v=%b, required s=5556 c=0 z=0 v=0", rs, rc, rz, rv);
    end
  endtask

  // Back-to-back random operations: each new request is issued on the first IDLE cycle.
  task automatic test_random_back_to_back();
    logic [N-1:0] ta, tb, rs, es;
    logic [1:0]   top;
    logic         tinv, ty, rc, rz, rv, ec, ez, ev;
    int           lat;
    for (int i = 0; i < 60; i++) begin
      ta = N'($urandom); tb = N'($urandom);
      if (i % 7 == 0) tb = ta;
      tinv = 1'($urandom); ty = 1'($urandom); top = 2'($urandom);
      model(ta, tb, tinv, ty, top, es, ec, ez, ev);
      do_op(ta, tb, tinv, ty, top, rs, rc, rz, rv, lat);
      checks++;
      if ({rs, rc, rz, rv, lat} !== {es, ec, ez, ev, WORDS}) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h inv=%b y=%b: got s=%h c=%b z=%b v=%b lat=%0d, required s=%h c=%b z=%b v=%b lat=%0d",
                 i, top, ta, tb, tinv, ty, rs, rc, rz, rv, lat, es, ec, ez, ev, WORDS);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; b_inv = 1'b0; y = 1'b0; op = 2'b00;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
